pong_match_ctrl: RTL and testbench

//  Match sequencer for the Pong datapath: owns serve/rally/point/pause/game-over flow.

---
 rtl/pong_match_ctrl_pkg.sv | 25 ++
 rtl/pong_match_ctrl_btn_edge.sv | 23 ++
 rtl/pong_match_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_match_ctrl_pkg.sv
// Shared types and constants for the Pong match sequencer: FSM state encoding,
// screen geometry and score nibble helpers.
package pong_match_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int SCORE_W       = 4;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Scores stick at the top of the nibble rather than wrapping back to zero.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/pong_match_ctrl_btn_edge.sv
// Button front end: two-flop synchroniser for an asynchronous pin followed by a
// rising-edge detector that produces a single-cycle pulse.
module pong_match_ctrl_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb sync_d = {sync_q[1:0], btn_i};

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    // sync_q[2] is only the history bit for edge detection, not a third sync stage.
    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/rally/point/pause/game-over flow, frame tick and move gating.
// Define PONG_WIN_BY_TWO_EN to require a two-point lead (or a saturated score) to win.
module pong_match_ctrl
    import pong_match_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV_W   = 16,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned WIN_SCORE   = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       point_p,
    input  logic       point_o,
    output logic       frame_tick,
    output logic       move_en,
    output logic       serve_req,
    output logic       serve_dir,
    output logic [7:0] score,
    output logic [2:0] state,
    output logic       game_over,
    output logic       winner
);

    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_DELAY - 1);

    logic [1:0] btn_rise;
    logic       start_rise, pause_rise;

    pong_match_ctrl_btn_edge u_btn [1:0] (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  ({pause_btn, start_btn}),
        .rise_o (btn_rise)
    );

    assign start_rise = btn_rise[0];
    assign pause_rise = btn_rise[1];

    logic [CLK_DIV_W-1:0] cnt_q, cnt_d;
    state_e               state_q, state_d, saved_q, saved_d;
    logic [7:0]           serve_cnt_q, serve_cnt_d;
    logic [SCORE_W-1:0]   p_q, p_d, o_q, o_d;
    logic                 serve_dir_q, serve_dir_d;
    logic                 winner_q, winner_d;
    logic                 serve_req_q, serve_req_d;
    logic                 last_p_q, last_p_d;

    logic [SCORE_W-1:0]   pts_scorer, pts_other;
    logic                 win;

    assign frame_tick = &cnt_q;

    // Win check runs in POINT on the already-updated score of whoever just scored.
    always_comb begin
        pts_scorer = last_p_q ? p_q : o_q;
        pts_other  = last_p_q ? o_q : p_q;
`ifdef PONG_WIN_BY_TWO_EN
        win = ((pts_scorer >= WIN_S) &&
               ({1'b0, pts_scorer} >= {1'b0, pts_other} + (SCORE_W+1)'(2))) ||
              (pts_scorer == SCORE_MAX);
`else
        win = (pts_scorer == WIN_S);
`endif
    end

    always_comb begin
        cnt_d       = cnt_q + CLK_DIV_W'(1);
        state_d     = state_q;
        saved_d     = saved_q;
        serve_cnt_d = serve_cnt_q;
        p_d         = p_q;
        o_d         = o_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        serve_req_d = 1'b0;
        last_p_d    = last_p_q;

        // A start edge (re)starts the match from anywhere except the one-cycle POINT state.
        if (start_rise && state_q != ST_POINT) begin
            p_d         = '0;
            o_d         = '0;
            serve_dir_d = 1'b1;
            serve_req_d = 1'b1;
            serve_cnt_d = '0;
            state_d     = ST_SERVE;
        end else begin
            case (state_q)
                ST_SERVE: begin
                    if (pause_rise) begin
                        saved_d = ST_SERVE;
                        state_d = ST_PAUSE;
                    end else if (frame_tick) begin
                        if (serve_cnt_q == SERVE_LAST) begin
                            serve_cnt_d = '0;
                            state_d     = ST_RALLY;
                        end else begin
                            serve_cnt_d = serve_cnt_q + 8'd1;
                        end
                    end
                end
                ST_RALLY: begin
                    if (pause_rise) begin
                        saved_d = ST_RALLY;
                        state_d = ST_PAUSE;
                    end else if (point_p) begin
                        p_d         = sat_inc(p_q);
                        serve_dir_d = 1'b0;
                        last_p_d    = 1'b1;
                        state_d     = ST_POINT;
                    end else if (point_o) begin
                        o_d         = sat_inc(o_q);
                        serve_dir_d = 1'b1;
                        last_p_d    = 1'b0;
                        state_d     = ST_POINT;
                    end
                end
                ST_POINT: begin
                    if (win) begin
                        winner_d = last_p_q;
                        state_d  = ST_OVER;
                    end else begin
                        serve_req_d = 1'b1;
                        serve_cnt_d = '0;
                        state_d     = ST_SERVE;
                    end
                end
                ST_PAUSE: begin
                    if (pause_rise) state_d = saved_q;
                end
                ST_IDLE, ST_OVER: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            saved_q     <= ST_IDLE;
            serve_cnt_q <= '0;
            p_q         <= '0;
            o_q         <= '0;
            serve_dir_q <= 1'b1;
            winner_q    <= 1'b0;
            serve_req_q <= 1'b0;
            last_p_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            saved_q     <= saved_d;
            serve_cnt_q <= serve_cnt_d;
            p_q         <= p_d;
            o_q         <= o_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            serve_req_q <= serve_req_d;
            last_p_q    <= last_p_d;
        end
    end

    assign move_en   = frame_tick && (state_q == ST_RALLY);
    assign serve_req = serve_req_q;
    assign serve_dir = serve_dir_q;
    assign score     = {o_q, p_q};
    assign state     = state_q;
    assign game_over = (state_q == ST_OVER);
    assign winner    = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl (CLK_DIV_W=4, SERVE_DELAY=3, WIN_SCORE=3)
// with a score/win reference model and randomized point timing and scorers.
module tb_pong_match_ctrl;

    localparam int CW = 4;
    localparam int SD = 3;
    localparam int WS = 3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_RALLY = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       point_p = 1'b0;
    logic       point_o = 1'b0;
    logic       frame_tick, move_en, serve_req, serve_dir, game_over, winner;
    logic [7:0] score;
    logic [2:0] state;

    int pass_cnt = 0;
    int total_cnt = 0;
    int mp = 0;
    int mo = 0;

    pong_match_ctrl #(.CLK_DIV_W(CW), .SERVE_DELAY(SD), .WIN_SCORE(WS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .point_p    (point_p),
        .point_o    (point_o),
        .frame_tick (frame_tick),
        .move_en    (move_en),
        .serve_req  (serve_req),
        .serve_dir  (serve_dir),
        .score      (score),
        .state      (state),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    function automatic bit model_win(input int sc, input int ot);
`ifdef PONG_WIN_BY_TWO_EN
        return ((sc >= WS) && (sc - ot >= 2)) || (sc >= 15);
`else
        return sc == WS;
`endif
    endfunction

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    function automatic logic [7:0] exp_score();
        int a, b;
        a = mo;
        b = mp;
        return {a[3:0], b[3:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        if (frame_tick !== 1'b1) begin
            total_cnt++;
            $display("FAIL tick_timeout: frame_tick=%b, want 1 within 40 cycles", frame_tick);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        repeat (3) step();
        start_btn = 1'b0;
    endtask

    task automatic press_pause();
        pause_btn = 1'b1;
        repeat (3) step();
        pause_btn = 1'b0;
    endtask

    // Walks a serve phase cycle by cycle, counting the frame ticks it consumes.
    task automatic run_serve(output int ticks, output int bad);
        int n;
        ticks = 0;
        bad = 0;
        n = 0;
        while (state === S_SERVE && n < 200) begin
            if (frame_tick === 1'b1) ticks++;
            if (move_en !== 1'b0) bad++;
            if (n > 0 && serve_req !== 1'b0) bad++;
            step();
            n++;
        end
    endtask

    task automatic play_point(input bit pl);
        int t, b;
        run_serve(t, b);
        repeat ($urandom_range(0, 6)) step();
        if (pl) begin
            point_p = 1'b1;
            mp = sat(mp);
        end else begin
            point_o = 1'b1;
            mo = sat(mo);
        end
        step();
        point_p = 1'b0;
        point_o = 1'b0;
        step();
    endtask

    task automatic test_reset();
        int first;
        rst_n = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (state !== S_IDLE || score !== 8'h00 || serve_dir !== 1'b1 || winner !== 1'b0 ||
            game_over !== 1'b0 || serve_req !== 1'b0 || frame_tick !== 1'b0 || move_en !== 1'b0)
            $display("FAIL reset_values: state=%0d score=%h dir=%b win=%b go=%b req=%b tick=%b mv=%b, want 0 00 1 0 0 0 0 0",
                     state, score, serve_dir, winner, game_over, serve_req, frame_tick, move_en);
        else pass_cnt++;
        rst_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (frame_tick === 1'b1 && first < 0) first = i;
        end
        total_cnt++;
        if (first != 15) $display("FAIL first_tick: tick on cycle %0d, want 15", first);
        else pass_cnt++;
    endtask

    task automatic test_serve();
        int t, b;
        repeat ($urandom_range(0, 20)) step();
        press_start();
        mp = 0;
        mo = 0;
        total_cnt++;
        if (state !== S_SERVE || serve_req !== 1'b1 || score !== 8'h00 || serve_dir !== 1'b1)
            $display("FAIL start_serve: state=%0d req=%b score=%h dir=%b, want 1 1 00 1",
                     state, serve_req, score, serve_dir);
        else pass_cnt++;
        run_serve(t, b);
        total_cnt++;
        if (t != SD || b != 0 || state !== S_RALLY)
            $display("FAIL serve_delay: ticks=%0d bad=%0d state=%0d, want %0d 0 2", t, b, state, SD);
        else pass_cnt++;
        wait_tick();
        total_cnt++;
        if (move_en !== 1'b1) $display("FAIL rally_move_en: move_en=%b, want 1", move_en);
        else pass_cnt++;
    endtask

    task automatic test_point();
        repeat ($urandom_range(0, 30)) step();
        point_p = 1'b1;
        mp = sat(mp);
        step();
        point_p = 1'b0;
        total_cnt++;
        if (state !== S_POINT || score !== exp_score() || serve_dir !== 1'b0)
            $display("FAIL point_p: state=%0d score=%h dir=%b, want 3 %h 0", state, score, serve_dir, exp_score());
        else pass_cnt++;
        step();
        total_cnt++;
        if (state !== S_SERVE || serve_req !== 1'b1)
            $display("FAIL point_to_serve: state=%0d req=%b, want 1 1", state, serve_req);
        else pass_cnt++;
    endtask

    task automatic test_both();
        int t, b;
        run_serve(t, b);
        repeat ($urandom_range(0, 10)) step();
        point_p = 1'b1;
        point_o = 1'b1;
        mp = sat(mp);
        step();
        point_p = 1'b0;
        point_o = 1'b0;
        total_cnt++;
        if (state !== S_POINT || score !== exp_score())
            $display("FAIL both_points: state=%0d score=%h, want 3 %h", state, score, exp_score());
        else pass_cnt++;
        step();
    endtask

    task automatic test_pause();
        int n, t, b;
        n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        step();
        press_pause();
        total_cnt++;
        if (state !== S_PAUSE) $display("FAIL pause_enter: state=%0d, want 4", state);
        else pass_cnt++;
        point_o = 1'b1;
        step();
        point_o = 1'b0;
        total_cnt++;
        if (score !== exp_score() || state !== S_PAUSE)
            $display("FAIL pause_ignores_point: score=%h state=%0d, want %h 4", score, state, exp_score());
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            wait_tick();
            total_cnt++;
            if (move_en !== 1'b0 || state !== S_PAUSE)
                $display("FAIL pause_hold: move_en=%b state=%0d, want 0 4", move_en, state);
            else pass_cnt++;
        end
        press_pause();
        total_cnt++;
        if (state !== S_SERVE) $display("FAIL unpause: state=%0d, want 1", state);
        else pass_cnt++;
        run_serve(t, b);
        total_cnt++;
        if (t != SD - 1 || b != 0 || state !== S_RALLY)
            $display("FAIL serve_resume: ticks=%0d bad=%0d state=%0d, want %0d 0 2", t, b, state, SD - 1);
        else pass_cnt++;
    endtask

    task automatic test_player_win();
        press_start();
        mp = 0;
        mo = 0;
        total_cnt++;
        if (state !== S_SERVE || score !== 8'h00)
            $display("FAIL restart_rally: state=%0d score=%h, want 1 00", state, score);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) play_point(1'b1);
        total_cnt++;
        if (state !== S_OVER || game_over !== 1'b1 || winner !== 1'b1 || score !== 8'h03)
            $display("FAIL player_win: state=%0d go=%b win=%b score=%h, want 5 1 1 03",
                     state, game_over, winner, score);
        else pass_cnt++;
        press_start();
        mp = 0;
        mo = 0;
        total_cnt++;
        if (state !== S_SERVE || score !== 8'h00 || serve_req !== 1'b1 || game_over !== 1'b0)
            $display("FAIL restart_over: state=%0d score=%h req=%b go=%b, want 1 00 1 0",
                     state, score, serve_req, game_over);
        else pass_cnt++;
    endtask

    task automatic test_win_margin();
        play_point(1'b0);
        play_point(1'b0);
        play_point(1'b1);
        play_point(1'b1);
        total_cnt++;
        if (state !== S_SERVE || score !== 8'h22)
            $display("FAIL deuce_2_2: state=%0d score=%h, want 1 22", state, score);
        else pass_cnt++;
        play_point(1'b1);
`ifdef PONG_WIN_BY_TWO_EN
        total_cnt++;
        if (state !== S_SERVE || score !== 8'h23)
            $display("FAIL margin_3_2: state=%0d score=%h, want 1 23", state, score);
        else pass_cnt++;
        play_point(1'b1);
        total_cnt++;
        if (state !== S_OVER || winner !== 1'b1 || score !== 8'h24)
            $display("FAIL margin_4_2: state=%0d win=%b score=%h, want 5 1 24", state, winner, score);
        else pass_cnt++;
`else
        total_cnt++;
        if (state !== S_OVER || winner !== 1'b1 || score !== 8'h23)
            $display("FAIL win_3_2: state=%0d win=%b score=%h, want 5 1 23", state, winner, score);
        else pass_cnt++;
`endif
    endtask

    task automatic test_random_match();
        int t, b, r;
        bit pl, done;
        press_start();
        mp = 0;
        mo = 0;
        done = 0;
        for (int it = 0; it < 40 && !done; it++) begin
            // Points arriving during the serve hold must be dropped.
            if (frame_tick !== 1'b1) begin
                point_p = 1'b1;
                step();
                point_p = 1'b0;
                total_cnt++;
                if (score !== exp_score()) $display("FAIL serve_ignores_point: score=%h, want %h", score, exp_score());
                else pass_cnt++;
            end
            run_serve(t, b);
            total_cnt++;
            if (t != SD || b != 0 || state !== S_RALLY)
                $display("FAIL rnd_serve: ticks=%0d bad=%0d state=%0d, want %0d 0 2", t, b, state, SD);
            else pass_cnt++;
            repeat ($urandom_range(0, 25)) step();
            r = $urandom_range(0, 2);
            pl = (r != 1);
            point_p = (r != 1);
            point_o = (r != 0);
            if (pl) mp = sat(mp); else mo = sat(mo);
            step();
            point_p = 1'b0;
            point_o = 1'b0;
            total_cnt++;
            if (state !== S_POINT || score !== exp_score() || serve_dir !== !pl)
                $display("FAIL rnd_point: state=%0d score=%h dir=%b, want 3 %h %b", state, score, serve_dir, exp_score(), !pl);
            else pass_cnt++;
            step();
            if (pl ? model_win(mp, mo) : model_win(mo, mp)) begin
                done = 1;
                total_cnt++;
                if (state !== S_OVER || game_over !== 1'b1 || winner !== pl)
                    $display("FAIL rnd_over: state=%0d go=%b win=%b, want 5 1 %b", state, game_over, winner, pl);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (state !== S_SERVE || serve_req !== 1'b1)
                    $display("FAIL rnd_next_serve: state=%0d req=%b, want 1 1", state, serve_req);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (!done) $display("FAIL rnd_match_end: match not over after 40 points, want over");
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int t, b;
        press_start();
        run_serve(t, b);
        repeat ($urandom_range(1, 10)) step();
        rst_n = 1'b0;
        step();
        total_cnt++;
        if (state !== S_IDLE || score !== 8'h00 || serve_dir !== 1'b1 || frame_tick !== 1'b0 ||
            serve_req !== 1'b0 || game_over !== 1'b0 || move_en !== 1'b0)
            $display("FAIL reset_mid: state=%0d score=%h dir=%b tick=%b req=%b go=%b mv=%b, want 0 00 1 0 0 0 0",
                     state, score, serve_dir, frame_tick, serve_req, game_over, move_en);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_serve();
        test_point();
        test_both();
        test_pause();
        test_player_win();
        test_win_margin();
        test_random_match();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
